// File: rtl/sensor_reg_sequencer_if.sv
// Handshake bundle between the register sequencer and the sensor serial controller.
// Signal names are seen from the sequencer side.
interface sensor_reg_sequencer_if;
  logic [6:0] address_o;
  logic [7:0] write_data_o;
  logic       write_valid_o;
  logic       read_start_o;
  logic       mux_ce_a_nd_o;
  logic       ctrl_busy_i;
  logic [7:0] read_data_i;

  modport master (
    output address_o,
    output write_data_o,
    output write_valid_o,
    output read_start_o,
    output mux_ce_a_nd_o,
    input  ctrl_busy_i,
    input  read_data_i
  );

  modport slave (
    input  address_o,
    input  write_data_o,
    input  write_valid_o,
    input  read_start_o,
    input  mux_ce_a_nd_o,
    output ctrl_busy_i,
    output read_data_i
  );
endinterface

// File: rtl/sensor_reg_sequencer.sv
// Table-driven register sequencer: walks a synchronous-read entry table and issues
// one serial write or read-and-verify at a time through the sensor controller.
module sensor_reg_sequencer #(
  parameter int ADDR_W      = 6,
  parameter int WAIT_UNIT   = 1000,
  parameter int ACK_TIMEOUT = 255
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 start_i,
  output logic                 busy_o,
  output logic                 done_o,
  output logic                 error_o,
  output logic [ADDR_W-1:0]    err_index_o,
  output logic [ADDR_W-1:0]    table_addr_o,
  input  logic [17:0]          table_data_i,
  sensor_reg_sequencer_if.master ctrl
);

  localparam logic [2:0] S_IDLE      = 3'd0;
  localparam logic [2:0] S_FETCH     = 3'd1;
  localparam logic [2:0] S_DECODE    = 3'd2;
  localparam logic [2:0] S_ISSUE     = 3'd3;
  localparam logic [2:0] S_WAIT_ACK  = 3'd4;
  localparam logic [2:0] S_WAIT_DONE = 3'd5;
  localparam logic [2:0] S_DELAY     = 3'd6;
  localparam logic [2:0] S_DONE      = 3'd7;

  localparam logic [1:0] OP_WRITE  = 2'b00;
  localparam logic [1:0] OP_VERIFY = 2'b01;
  localparam logic [1:0] OP_WAIT   = 2'b10;
  localparam logic [1:0] OP_END    = 2'b11;

  // One counter serves both the delay ticks and the acknowledge timeout.
  localparam int DLY_W = 8 + $clog2(WAIT_UNIT);
  localparam int TO_W  = $clog2(ACK_TIMEOUT + 1);
  localparam int CNT_W = (DLY_W > TO_W) ? DLY_W : TO_W;

  localparam logic [CNT_W-1:0]  WAIT_CNT = CNT_W'(WAIT_UNIT);
  localparam logic [CNT_W-1:0]  TO_CNT   = CNT_W'(ACK_TIMEOUT);
  localparam logic [CNT_W-1:0]  CNT_ONE  = CNT_W'(1);
  localparam logic [ADDR_W-1:0] LAST_IDX = {ADDR_W{1'b1}};

  logic [2:0]        state_q,   state_d;
  logic [ADDR_W-1:0] idx_q,     idx_d;
  logic [1:0]        op_q,      op_d;
  logic [6:0]        addr_q,    addr_d;
  logic [7:0]        wdata_q,   wdata_d;
  logic              ce_q,      ce_d;
  logic [CNT_W-1:0]  cnt_q,     cnt_d;
  logic              busy_q,    busy_d;
  logic              done_q,    done_d;
  logic              err_q,     err_d;
  logic [ADDR_W-1:0] err_idx_q, err_idx_d;

  logic advance;
  logic fail;
  logic finish;
  logic issue_fire;

  // Requests are a direct decode of ISSUE so they drop the same cycle busy is seen.
  assign issue_fire = (state_q == S_ISSUE) && !ctrl.ctrl_busy_i;

  // NOTE: every variable assigned here gets a default first, so no path leaves one
  // unassigned and no latch is inferred.
  always_comb begin
    state_d   = state_q;
    idx_d     = idx_q;
    op_d      = op_q;
    addr_d    = addr_q;
    wdata_d   = wdata_q;
    ce_d      = ce_q;
    cnt_d     = cnt_q;
    busy_d    = busy_q;
    done_d    = 1'b0;
    err_d     = err_q;
    err_idx_d = err_idx_q;
    advance   = 1'b0;
    fail      = 1'b0;
    finish    = 1'b0;

    case (state_q)
      S_IDLE: begin
        if (start_i) begin
          idx_d     = '0;
          err_d     = 1'b0;
          err_idx_d = '0;
          busy_d    = 1'b1;
          state_d   = S_FETCH;
        end
      end

      S_FETCH: state_d = S_DECODE;

      S_DECODE: begin
        op_d    = table_data_i[17:16];
        ce_d    = table_data_i[15];
        addr_d  = table_data_i[14:8];
        wdata_d = table_data_i[7:0];
        case (table_data_i[17:16])
          OP_WRITE, OP_VERIFY: state_d = S_ISSUE;
          OP_WAIT: begin
            if (table_data_i[7:0] == 8'd0) begin
              advance = 1'b1;
            end else begin
              cnt_d   = CNT_W'(table_data_i[7:0]) * WAIT_CNT;
              state_d = S_DELAY;
            end
          end
          default: finish = 1'b1;
        endcase
      end

      S_ISSUE: begin
        if (!ctrl.ctrl_busy_i) begin
          cnt_d   = TO_CNT;
          state_d = S_WAIT_ACK;
        end
      end

      S_WAIT_ACK: begin
        if (ctrl.ctrl_busy_i) begin
          state_d = S_WAIT_DONE;
        end else if (cnt_q <= CNT_ONE) begin
          fail = 1'b1;
        end else begin
          cnt_d = cnt_q - CNT_ONE;
        end
      end

      S_WAIT_DONE: begin
        if (!ctrl.ctrl_busy_i) begin
          if (op_q == OP_VERIFY && ctrl.read_data_i != wdata_q) begin
            fail = 1'b1;
          end else begin
            advance = 1'b1;
          end
        end
      end

      S_DELAY: begin
        if (cnt_q <= CNT_ONE) begin
          advance = 1'b1;
        end else begin
          cnt_d = cnt_q - CNT_ONE;
        end
      end

      S_DONE:  state_d = S_IDLE;

      default: state_d = S_IDLE;
    endcase

    // Running off the last table slot is an implicit END, not an error.
    if (advance) begin
      if (idx_q == LAST_IDX) begin
        finish = 1'b1;
      end else begin
        idx_d   = idx_q + ADDR_W'(1);
        state_d = S_FETCH;
      end
    end

    if (fail) begin
      err_d     = 1'b1;
      err_idx_d = idx_q;
      finish    = 1'b1;
    end

    if (finish) begin
      state_d = S_DONE;
      done_d  = 1'b1;
      busy_d  = 1'b0;
    end
  end

  // NOTE: state registers use non-blocking assignments so every flop samples the
  // values from before the edge, independent of statement order.
  always_ff @(posedge clk) begin
    // NOTE: reset is synchronous; a reset mid-transaction simply returns to IDLE
    // without a done pulse because done_q is cleared here, not set.
    if (rst) begin
      state_q   <= S_IDLE;
      idx_q     <= '0;
      op_q      <= OP_WRITE;
      addr_q    <= '0;
      wdata_q   <= '0;
      ce_q      <= 1'b0;
      cnt_q     <= '0;
      busy_q    <= 1'b0;
      done_q    <= 1'b0;
      err_q     <= 1'b0;
      err_idx_q <= '0;
    end else begin
      state_q   <= state_d;
      idx_q     <= idx_d;
      op_q      <= op_d;
      addr_q    <= addr_d;
      wdata_q   <= wdata_d;
      ce_q      <= ce_d;
      cnt_q     <= cnt_d;
      busy_q    <= busy_d;
      done_q    <= done_d;
      err_q     <= err_d;
      err_idx_q <= err_idx_d;
    end
  end

  assign busy_o       = busy_q;
  assign done_o       = done_q;
  assign error_o      = err_q;
  assign err_index_o  = err_idx_q;
  assign table_addr_o = idx_q;

  assign ctrl.address_o     = addr_q;
  assign ctrl.write_data_o  = wdata_q;
  assign ctrl.mux_ce_a_nd_o = ce_q;
  assign ctrl.write_valid_o = issue_fire && (op_q == OP_WRITE);
  assign ctrl.read_start_o  = issue_fire && (op_q == OP_VERIFY);

endmodule

// File: tb/tb_sensor_reg_sequencer.sv
// Self-checking bench: a timeline model derives request/done cycles from the table
// and a controller model; one compare process checks the DUT every cycle of a run.
module tb_sensor_reg_sequencer;
  localparam int ADDR_W = 2;
  localparam int WU     = 4;
  localparam int ACK_TO = 20;
  localparam int TAIL   = 4;

  logic              clk = 1'b0;
  logic              rst;
  logic              start_i;
  logic              busy_o, done_o, error_o;
  logic [ADDR_W-1:0] err_index_o, table_addr_o;
  logic [17:0]       table_data;

  sensor_reg_sequencer_if ctrl_if ();

  sensor_reg_sequencer #(.ADDR_W(ADDR_W), .WAIT_UNIT(WU), .ACK_TIMEOUT(ACK_TO)) dut (
    .clk          (clk),
    .rst          (rst),
    .start_i      (start_i),
    .busy_o       (busy_o),
    .done_o       (done_o),
    .error_o      (error_o),
    .err_index_o  (err_index_o),
    .table_addr_o (table_addr_o),
    .table_data_i (table_data),
    .ctrl         (ctrl_if)
  );

  always #5 clk = ~clk;

  // Table memory with one cycle of read latency.
  logic [17:0] tbl [4];
  always @(posedge clk) table_data <= tbl[table_addr_o];

  // Controller model: busy rises the cycle after a request and lasts busy_len cycles.
  int         busy_len;
  bit         responsive;
  logic [7:0] rdata;
  int         bcnt;
  always @(posedge clk) begin
    if (rst) bcnt <= 0;
    else if ((ctrl_if.write_valid_o || ctrl_if.read_start_o) && responsive) bcnt <= busy_len;
    else if (bcnt != 0) bcnt <= bcnt - 1;
  end
  assign ctrl_if.ctrl_busy_i = (bcnt != 0);
  assign ctrl_if.read_data_i = rdata;

  int total = 0;
  int bad   = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  function automatic logic [17:0] ent(input logic [1:0] op, input bit ce,
                                      input logic [6:0] a, input logic [7:0] d);
    return {op, ce, a, d};
  endfunction

  typedef struct {
    int         cyc;
    bit         rd;
    logic [6:0] addr;
    logic [7:0] data;
    bit         ce;
  } req_t;

  req_t exp_q[$];
  int   exp_done, exp_eidx, exp_last;
  bit   exp_err;

  // Walk the table entry by entry: cycle 0 samples start, each fetch is followed by
  // decode; requests go out two cycles after fetch; the cycle after the controller
  // drops busy (or the last delay tick) starts the next fetch.
  task automatic build_model();
    int f, d, iss, a, idx;
    bit stop;
    logic [17:0] e;
    req_t r;
    exp_q.delete();
    exp_err = 1'b0; exp_eidx = 0;
    f = 1; idx = 0; stop = 1'b0; a = 0;
    while (!stop) begin
      e = tbl[idx];
      d = f + 1;
      case (e[17:16])
        2'b11: begin exp_done = d + 1; stop = 1'b1; end
        2'b10: a = d + int'(e[7:0]) * WU;
        default: begin
          iss    = f + 2;
          r.cyc  = iss;
          r.rd   = (e[17:16] == 2'b01);
          r.addr = e[14:8];
          r.data = e[7:0];
          r.ce   = e[15];
          exp_q.push_back(r);
          if (!responsive) begin
            exp_done = iss + ACK_TO + 1; exp_err = 1'b1; exp_eidx = idx; stop = 1'b1;
          end else begin
            a = iss + 1 + busy_len;
            if (r.rd && rdata != e[7:0]) begin
              exp_done = a + 1; exp_err = 1'b1; exp_eidx = idx; stop = 1'b1;
            end
          end
        end
      endcase
      if (!stop) begin
        if (idx == 3) begin exp_done = a + 1; stop = 1'b1; end
        else begin idx++; f = a + 1; end
      end
    end
    exp_last = idx;
  endtask

  // Compare process
  bit   active = 1'b0;
  int   cyc;
  int   first_req_cyc, req_seen;
  bit   e_wv, e_rs;
  req_t cur;

  always @(negedge clk) begin
    if (active) begin
      e_wv = 1'b0; e_rs = 1'b0;
      if (exp_q.size() > 0 && exp_q[0].cyc == cyc) begin
        cur  = exp_q.pop_front();
        e_wv = !cur.rd;
        e_rs = cur.rd;
        check("address", ctrl_if.address_o, cur.addr);
        check("write_data", ctrl_if.write_data_o, cur.data);
        check("mux_ce", ctrl_if.mux_ce_a_nd_o, cur.ce);
      end
      check("write_valid", ctrl_if.write_valid_o, e_wv);
      check("read_start", ctrl_if.read_start_o, e_rs);
      if (ctrl_if.write_valid_o || ctrl_if.read_start_o) begin
        req_seen++;
        if (first_req_cyc < 0) first_req_cyc = cyc;
      end
      check("done", done_o, cyc == exp_done);
      check("busy", busy_o, cyc >= 1 && cyc < exp_done);
      if (cyc >= 1) begin
        check("error", error_o, (cyc >= exp_done) ? exp_err : 1'b0);
        check("err_index", err_index_o, (cyc >= exp_done && exp_err) ? exp_eidx : 0);
      end
      if (cyc == exp_done) check("table_addr", table_addr_o, exp_last);
      if (cyc == exp_done + TAIL) active = 1'b0;
      cyc++;
    end
  end

  task automatic run(input bit spam);
    build_model();
    @(posedge clk); #1;
    start_i = 1'b1; cyc = 0; first_req_cyc = -1; req_seen = 0; active = 1'b1;
    @(posedge clk); #1;
    start_i = 1'b0;
    for (int k = 0; k < 2000 && active; k++) begin
      @(posedge clk); #1;
      start_i = spam && (k == 2 || k == 5 || k == 9 || k == 17);
    end
    start_i = 1'b0;
    check("run_timeout", active, 1'b0);
    active = 1'b0;
  endtask

  task automatic check_all_zero(input string tag);
    check({tag, "_busy"}, busy_o, 0);
    check({tag, "_done"}, done_o, 0);
    check({tag, "_error"}, error_o, 0);
    check({tag, "_eidx"}, err_index_o, 0);
    check({tag, "_taddr"}, table_addr_o, 0);
    check({tag, "_addr"}, ctrl_if.address_o, 0);
    check({tag, "_wdata"}, ctrl_if.write_data_o, 0);
    check({tag, "_wv"}, ctrl_if.write_valid_o, 0);
    check({tag, "_rs"}, ctrl_if.read_start_o, 0);
    check({tag, "_ce"}, ctrl_if.mux_ce_a_nd_o, 0);
  endtask

  initial begin
    rst = 1'b1; start_i = 1'b0;
    responsive = 1'b1; busy_len = 40; rdata = 8'h00;
    for (int i = 0; i < 4; i++) tbl[i] = ent(2'b11, 1'b0, 7'h0, 8'h0);
    repeat (3) @(posedge clk);
    @(negedge clk);
    check_all_zero("reset");
    @(posedge clk); #1;
    rst = 1'b0;

    // Single write with start spammed while busy.
    tbl[0] = ent(2'b00, 1'b1, 7'h12, 8'hA5);
    run(1'b1);
    check("t1_model_done", exp_done, 47);
    check("t1_first_req", first_req_cyc, 3);
    check("t1_req_count", req_seen, 1);

    // Verify with matching data.
    tbl[0] = ent(2'b01, 1'b0, 7'h05, 8'h3C);
    busy_len = 5; rdata = 8'h3C;
    run(1'b0);
    check("t2_req_count", req_seen, 1);
    check("t2_error", error_o, 0);

    // Verify mismatch.
    rdata = 8'h3D;
    run(1'b0);
    check("t3_req_count", req_seen, 1);
    check("t3_error", error_o, 1);
    check("t3_eidx", err_index_o, 0);

    // Delay of 3 ticks before a write.
    tbl[0] = ent(2'b10, 1'b0, 7'h00, 8'd3);
    tbl[1] = ent(2'b00, 1'b0, 7'h33, 8'h77);
    tbl[2] = ent(2'b11, 1'b0, 7'h00, 8'h00);
    run(1'b0);
    check("t4_first_req", first_req_cyc, 17);
    check("t4_error", error_o, 0);

    // Controller never acknowledges.
    tbl[0] = ent(2'b00, 1'b0, 7'h01, 8'h02);
    tbl[1] = ent(2'b11, 1'b0, 7'h00, 8'h00);
    responsive = 1'b0;
    run(1'b0);
    check("t5_model_done", exp_done, 24);
    check("t5_error", error_o, 1);
    check("t5_eidx", err_index_o, 0);
    responsive = 1'b1;

    // Zero-length wait then a failing verify deeper in the table.
    tbl[0] = ent(2'b00, 1'b1, 7'h10, 8'h11);
    tbl[1] = ent(2'b10, 1'b0, 7'h00, 8'h00);
    tbl[2] = ent(2'b01, 1'b1, 7'h22, 8'h44);
    tbl[3] = ent(2'b11, 1'b0, 7'h00, 8'h00);
    rdata = 8'h45;
    run(1'b0);
    check("t6_error", error_o, 1);
    check("t6_eidx", err_index_o, 2);
    check("t6_req_count", req_seen, 2);

    // Reset during WAIT_DONE: everything clears next cycle, no done pulse.
    tbl[0] = ent(2'b00, 1'b1, 7'h12, 8'hA5);
    tbl[1] = ent(2'b11, 1'b0, 7'h00, 8'h00);
    busy_len = 40;
    @(posedge clk); #1;
    start_i = 1'b1;
    @(posedge clk); #1;
    start_i = 1'b0;
    repeat (10) @(posedge clk);
    #1;
    check("t7_pre_busy", busy_o, 1);
    rst = 1'b1;
    @(posedge clk);
    @(negedge clk);
    check_all_zero("t7_rst");
    @(posedge clk); #1;
    rst = 1'b0;
    for (int k = 0; k < 5; k++) begin
      @(negedge clk);
      check("t7_no_done", done_o, 0);
    end

    // Fresh start: four writes filling the table, implicit end.
    for (int i = 0; i < 4; i++) tbl[i] = ent(2'b00, i[0], 7'(8'h40 + i), 8'(8'hC0 + i));
    busy_len = 3;
    run(1'b0);
    check("t8_model_done", exp_done, 29);
    check("t8_first_req", first_req_cyc, 3);
    check("t8_req_count", req_seen, 4);
    check("t8_error", error_o, 0);
    check("t8_taddr", table_addr_o, 3);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule

// File: doc/sensor_reg_sequencer.md
# sensor_reg_sequencer

Table-driven register sequencer that sits directly upstream of the sensor serial controller. It walks an external, synchronous-read table of entries (write, read-and-verify, delay, end). It issues one serial transaction at a time through the controller's write_valid/read_start/busy handshake and selects the analog or digital chip-enable for each entry. It is used for sensor power-up and mode-switch register programming, and reports completion, a sticky error flag and the failing table index.

## Interface
- ADDR_W, 6: table index width; table depth is 2^ADDR_W.
- WAIT_UNIT, 1000: clk cycles per delay tick.
- ACK_TIMEOUT, 255: max cycles to wait for ctrl_busy_i to rise after an issue pulse.

Ports:
- clk  in  1  system clock.
- rst  in  1  reset, synchronous, active-high.
- start_i  in  1  start the sequence at index 0; sampled only in IDLE.
- busy_o  out  1  sequence running.
- done_o  out  1  one-cycle pulse when the sequence ends (success or abort).
- error_o  out  1  sticky error; cleared on the next accepted start.
- err_index_o  out  ADDR_W  index of the failing entry.
- table_addr_o  out  ADDR_W  table read address (registered).
- table_data_i  in  18  entry, valid 1 cycle after table_addr_o changes. Fields:
  - [17:16] op: 00 WRITE, 01 VERIFY, 10 WAIT, 11 END.
  - [15] sel_a: 1 = analog CE.
  - [14:8] reg addr.
  - [7:0] data.
- address_o  out  7  to controller address_i.
- write_data_o  out  8  to controller write_data_i.
- write_valid_o  out  1  one-cycle write request.
- read_start_o  out  1  one-cycle read request.
- mux_ce_a_nd_o  out  1  CE select to controller.
- ctrl_busy_i  in  1  controller busy_o.
- read_data_i  in  8  controller read_data_o.

## Operation
- States are IDLE, FETCH, DECODE, ISSUE, WAIT_ACK, WAIT_DONE, DELAY, DONE.
- IDLE:
  - On start_i, set table_addr_o <= 0, clear error_o and err_index_o, set busy_o <= 1, then go to FETCH.
  - start_i outside IDLE is ignored.
- FETCH: one-cycle table latency, then DECODE.
- DECODE: latch the entry and drive address_o, write_data_o and mux_ce_a_nd_o from its fields. Branch on op:
  - WRITE or VERIFY: go to ISSUE.
  - WAIT: load the counter with data×WAIT_UNIT. Go to DELAY, or advance directly if data = 0.
  - END: go to DONE.
- ISSUE:
  - Hold while ctrl_busy_i = 1.
  - Otherwise assert write_valid_o (WRITE) or read_start_o (VERIFY) for exactly one cycle, load the timeout counter, and go to WAIT_ACK.
- WAIT_ACK:
  - When ctrl_busy_i = 1, go to WAIT_DONE.
  - After ACK_TIMEOUT cycles without it, set error_o, set err_index_o = index, and go to DONE.
- WAIT_DONE: when ctrl_busy_i = 0, the transaction is complete.
  - VERIFY: compare read_data_i against data. On mismatch, set error_o, set err_index_o = index, and go to DONE.
  - Otherwise advance.
- DELAY: decrement each cycle; at 0, advance.
- Advance:
  - If index = 2^ADDR_W−1, go to DONE (implicit END, no error).
  - Else table_addr_o <= index+1, then FETCH.
- DONE: pulse done_o for one cycle, clear busy_o, go to IDLE.
- address_o, write_data_o and mux_ce_a_nd_o are held stable from DECODE until the next DECODE, so CE selection never changes mid-transaction.
- Delay counter width is 8 + clog2(WAIT_UNIT) bits. Multiplication overflow is impossible by construction.
- Reset behaviour:
  - Every output goes to 0: busy_o, done_o, error_o, err_index_o, table_addr_o, address_o, write_data_o, write_valid_o, read_start_o, mux_ce_a_nd_o. State goes to IDLE.
  - Reset mid-transaction aborts without a done_o pulse. The controller shares rst and is reset in the same cycle.

## Timing
- start_i is sampled at edge 0. FETCH is cycle 1, DECODE cycle 2.
- The first write_valid_o/read_start_o is high in cycle 3 if ctrl_busy_i = 0.
- The controller raises busy the cycle after the request, so WAIT_ACK normally lasts 1 cycle.
- Entry-to-entry overhead outside the controller is 5 cycles: advance, FETCH, DECODE, ISSUE, WAIT_ACK.
- WAIT entry with data = d: DECODE plus d×WAIT_UNIT DELAY cycles, then advance.
- END at index k: done_o is high in the cycle after DECODE of k; busy_o falls in the same cycle as done_o.
- read_data_i is sampled in the first cycle ctrl_busy_i is observed low in WAIT_DONE.
- Request pulses never exceed one cycle and are never issued while ctrl_busy_i = 1.

## Test plan
- Table [WRITE a=0x12 d=0xA5 sel_a=1, END], with a controller model (busy 1 cycle after request, 40 cycles long):
  - write_valid_o is high exactly one cycle, at cycle 3, with address_o = 0x12, write_data_o = 0xA5, mux_ce_a_nd_o = 1.
  - done_o pulses once, error_o = 0.
- Table [VERIFY a=0x05 d=0x3C, END] with model read data 0x3C:
  - read_start_o pulses once, no error.
  - Repeating with read data 0x3D gives error_o = 1, err_index_o = 0, done_o pulse, no further requests.
- Table [WAIT d=3, WRITE, END] with WAIT_UNIT = 4: the write request appears 12 DELAY cycles after WAIT's DECODE.
- Model that never raises busy: after ACK_TIMEOUT cycles, error_o = 1, err_index_o = 0, done_o pulse.
- Reset and restart:
  - start_i pulsed repeatedly while busy_o = 1 has no effect.
  - rst asserted during WAIT_DONE drives all outputs to 0 the next cycle with no done_o pulse.
  - A fresh start then runs from index 0.
- ADDR_W = 2 table of four WRITEs with no END: four requests, then done_o with error_o = 0 and no fetch of a fifth entry.
